// File: rtl/edib_mode2_tx_ctrl.sv
// edib_mode2_tx_ctrl: EDIB mode-2 serial transmit controller with two-source round-robin arbitration
// Ports:
//   clk_12m          12 MHz system clock
//   reset            asynchronous active-low reset
//   req0/data0/ack0  status requester: word valid, word, one-cycle accept pulse
//   req1/data1/ack1  data requester: word valid, word, one-cycle accept pulse
//   clk_send         generated bit clock (period 2*HALF_DIV cycles)
//   tx_data          serial line data, changes only on the clk_send falling tick
//   tx_en            high while start, data and parity bits are on the line
//   busy             high from grant until the end-of-gap tick
//   grant_id         source of the current/last frame
// Build option: define EDIB_MODE2_PARITY_EN to insert an odd parity bit after the data LSB.
module edib_mode2_tx_ctrl #(
   parameter int HALF_DIV = 72,
   parameter int WORD_W   = 16,
   parameter int GAP_BITS = 2
) (
   input  logic              clk_12m,
   input  logic              reset,
   input  logic              req0,
   input  logic [WORD_W-1:0] data0,
   output logic              ack0,
   input  logic              req1,
   input  logic [WORD_W-1:0] data1,
   output logic              ack1,
   output logic              clk_send,
   output logic              tx_data,
   output logic              tx_en,
   output logic              busy,
   output logic              grant_id
);
   localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int BW = $clog2((WORD_W > GAP_BITS) ? WORD_W : GAP_BITS) + 1;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_GAP} state_t;
   state_t            r_state;
   logic [CW-1:0]     r_half;
   logic [BW-1:0]     r_bit;
   logic [WORD_W-1:0] r_shift;
   logic              r_last, r_clk_send, r_tx_data, r_tx_en, r_busy, r_ack0, r_ack1, r_grant_id;
`ifdef EDIB_MODE2_PARITY_EN
   logic              r_par;
`endif
   logic              w_tc, w_tick, w_req, w_gnt;
   logic [WORD_W-1:0] w_word;
   assign w_tc   = r_half == CW'(HALF_DIV - 1);
   // every line change happens on the clk_send falling tick
   assign w_tick = w_tc & r_clk_send;
   assign w_req  = req0 | req1;
   // on a tie the source that did not win last time is served
   assign w_gnt  = (req0 & req1) ? ~r_last : req1;
   assign w_word = w_gnt ? data1 : data0;
   always_ff @(posedge clk_12m or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_half     <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_last     <= 1'b1;
         r_clk_send <= 1'b0;
         r_tx_data  <= 1'b0;
         r_tx_en    <= 1'b0;
         r_busy     <= 1'b0;
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
         r_grant_id <= 1'b0;
`ifdef EDIB_MODE2_PARITY_EN
         r_par      <= 1'b0;
`endif
      end else begin
         r_half <= w_tc ? '0 : r_half + CW'(1);
         if (w_tc) r_clk_send <= ~r_clk_send;
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         if (w_tick) begin
            case (r_state)
               // the end-of-gap tick arbitrates too, so frames can run back to back
               S_IDLE, S_GAP:
                  if (r_state == S_GAP && r_bit != '0) r_bit <= r_bit - BW'(1);
                  else if (w_req) begin
                     r_shift    <= w_word;
`ifdef EDIB_MODE2_PARITY_EN
                     r_par      <= ~^w_word;
`endif
                     r_grant_id <= w_gnt;
                     r_last     <= w_gnt;
                     r_ack0     <= ~w_gnt;
                     r_ack1     <= w_gnt;
                     r_busy     <= 1'b1;
                     r_tx_en    <= 1'b1;
                     r_tx_data  <= 1'b1;
                     r_state    <= S_START;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               S_START: begin
                  r_tx_data <= r_shift[WORD_W-1];
                  r_shift   <= r_shift << 1;
                  r_bit     <= BW'(WORD_W - 1);
                  r_state   <= S_DATA;
               end
               S_DATA:
                  if (r_bit != '0) begin
                     r_tx_data <= r_shift[WORD_W-1];
                     r_shift   <= r_shift << 1;
                     r_bit     <= r_bit - BW'(1);
                  end else begin
`ifdef EDIB_MODE2_PARITY_EN
                     r_tx_data <= r_par;
                     r_state   <= S_PARITY;
                  end
               S_PARITY: begin
`endif
                     r_tx_data <= 1'b0;
                     r_tx_en   <= 1'b0;
                     r_bit     <= BW'(GAP_BITS - 1);
                     r_state   <= S_GAP;
                  end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end
   assign ack0     = r_ack0;
   assign ack1     = r_ack1;
   assign clk_send = r_clk_send;
   assign tx_data  = r_tx_data;
   assign tx_en    = r_tx_en;
   assign busy     = r_busy;
   assign grant_id = r_grant_id;
endmodule

// File: tb/tb_edib_mode2_tx_ctrl.sv
// tb_edib_mode2_tx_ctrl: self-checking bench for the EDIB mode-2 transmit controller
module tb_edib_mode2_tx_ctrl;
   localparam int HD = 72, W = 16, GB = 2;
`ifdef EDIB_MODE2_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NB = 1 + W + PB + GB;
   localparam int FRAME = NB * 2 * HD;
   logic clk_12m = 0, reset = 0, req0 = 0, req1 = 0;
   logic [W-1:0] data0 = '0, data1 = '0;
   logic ack0, ack1, clk_send, tx_data, tx_en, busy, grant_id;
   int checks = 0, failures = 0, cyc = 0, ack_err = 0, ack_cnt = 0;
   logic pa0 = 0, pa1 = 0;
   bit last_model = 1;
   typedef struct {
      bit r0, r1;
      logic [W-1:0] d0, d1;
      bit exp_id;
      logic [W-1:0] exp_w;
      bit exp_par;
   } vec_t;
   vec_t tv[6];

   edib_mode2_tx_ctrl dut (
      .clk_12m(clk_12m), .reset(reset),
      .req0(req0), .data0(data0), .ack0(ack0),
      .req1(req1), .data1(data1), .ack1(ack1),
      .clk_send(clk_send), .tx_data(tx_data), .tx_en(tx_en),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk_12m = ~clk_12m;
   always @(posedge clk_12m) cyc <= cyc + 1;
   // acks must be single-cycle and never simultaneous
   always @(negedge clk_12m) begin
      if ((ack0 && ack1) || (ack0 && pa0) || (ack1 && pa1)) ack_err <= ack_err + 1;
      if (ack0 || ack1) ack_cnt <= ack_cnt + 1;
      pa0 <= ack0;
      pa1 <= ack1;
   end

   initial begin
      #(95000 * 10);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_rise(output bit ok);
      int n = 0;
      while (clk_send !== 1'b0 && n < 4 * HD) begin @(negedge clk_12m); n++; end
      while (clk_send !== 1'b1 && n < 4 * HD) begin @(negedge clk_12m); n++; end
      ok = (clk_send === 1'b1);
   endtask

   task automatic wait_ack(output bit id, output int at, output bit ok);
      int n = 0;
      @(negedge clk_12m);
      while (!(ack0 === 1'b1 || ack1 === 1'b1) && n < 3 * FRAME) begin @(negedge clk_12m); n++; end
      ok = (ack0 === 1'b1 || ack1 === 1'b1);
      id = (ack1 === 1'b1);
      at = cyc;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL ack_timeout actual=none required=ack");
      end
   endtask

   // expected line: start 1, word MSB first, optional odd parity, GB idle gap bits
   task automatic check_frame(input logic [W-1:0] w, input bit par, input string name);
      bit eb[$];
      bit ee[$];
      int bad = 0;
      bit ok;
      string first = "";
      eb.push_back(1'b1); ee.push_back(1'b1);
      for (int i = W - 1; i >= 0; i--) begin eb.push_back(w[i]); ee.push_back(1'b1); end
      if (PB == 1) begin eb.push_back(par); ee.push_back(1'b1); end
      for (int i = 0; i < GB; i++) begin eb.push_back(1'b0); ee.push_back(1'b0); end
      for (int k = 0; k < NB; k++) begin
         wait_rise(ok);
         if (!ok || tx_data !== eb[k] || tx_en !== ee[k] || busy !== 1'b1) begin
            if (bad == 0)
               first = $sformatf("bit%0d got en=%b d=%b busy=%b want en=%b d=%b busy=1",
                                 k, tx_en, tx_data, busy, ee[k], eb[k]);
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL frame_%s word=%h bad_bits=%0d %s", name, w, bad, first);
      end
   endtask

   initial begin
      bit ok, id;
      int at, prev, hi, lo, act;
      tv[0] = '{0, 1, 16'h0000, 16'h0000, 1, 16'h0000, 1};
      tv[1] = '{0, 1, 16'h0000, 16'h0001, 1, 16'h0001, 0};
      tv[2] = '{1, 1, 16'h1234, 16'hFFFF, 0, 16'h1234, 0};
      tv[3] = '{1, 1, 16'h0F0F, 16'h8001, 1, 16'h8001, 1};
      tv[4] = '{1, 1, 16'hFFFE, 16'h7FFF, 0, 16'hFFFE, 0};
      tv[5] = '{1, 0, 16'h0000, 16'h1111, 0, 16'h0000, 1};

      // reset values
      repeat (3) @(negedge clk_12m);
      chk("rst_clk_send", clk_send, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_en", tx_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_ack", {ack0, ack1}, 0);
      reset = 1;

      // idle: bit clock 72 high / 72 low, quiet line, no ack
      hi = 0; lo = 0; act = 0;
      wait_rise(ok);
      while (clk_send === 1'b1 && hi < 400) begin
         if (tx_en || tx_data) act++;
         @(negedge clk_12m); hi++;
      end
      while (clk_send === 1'b0 && lo < 400) begin
         if (tx_en || tx_data) act++;
         @(negedge clk_12m); lo++;
      end
      chk("clk_send_high", hi, HD);
      chk("clk_send_low", lo, HD);
      chk("idle_line", act, 0);
      chk("idle_no_ack", ack_cnt, 0);

      // single req0 frame and busy length
      data0 = 16'hA5C3; req0 = 1;
      wait_ack(id, at, ok);
      req0 = 0; data0 = 16'hFFFF;
      chk("first_ack_id", id, 0);
      chk("first_grant_id", grant_id, 0);
      check_frame(16'hA5C3, 1'b1, "a5c3");
      hi = 0;
      while (busy === 1'b1 && hi < 4 * HD) begin @(negedge clk_12m); hi++; end
      chk("busy_len", cyc - at, FRAME);
      last_model = 0;

      // table vectors
      foreach (tv[i]) begin
         req0 = tv[i].r0; req1 = tv[i].r1; data0 = tv[i].d0; data1 = tv[i].d1;
         wait_ack(id, at, ok);
         req0 = 0; req1 = 0; data0 = W'($urandom); data1 = W'($urandom);
         chk($sformatf("tv%0d_ack_id", i), id, tv[i].exp_id);
         chk($sformatf("tv%0d_grant_id", i), grant_id, tv[i].exp_id);
         if (ok) check_frame(tv[i].exp_w, tv[i].exp_par, $sformatf("tv%0d", i));
         last_model = tv[i].exp_id;
      end

      // both held: alternating, back-to-back grants
      req0 = 1; req1 = 1; data0 = 16'hAAAA; data1 = 16'h5555; prev = 0;
      for (int j = 0; j < 4; j++) begin
         wait_ack(id, at, ok);
         if (j == 3) begin req0 = 0; req1 = 0; end
         chk($sformatf("alt%0d_id", j), id, !last_model);
         chk($sformatf("alt%0d_grant_id", j), grant_id, !last_model);
         if (j > 0) chk($sformatf("alt%0d_spacing", j), at - prev, FRAME);
         last_model = !last_model;
         prev = at;
         if (ok) check_frame(last_model ? 16'h5555 : 16'hAAAA, last_model ? 1'b1 : 1'b1,
                             $sformatf("alt%0d", j));
      end
      hi = 0;
      while (busy === 1'b1 && hi < 4 * HD) begin @(negedge clk_12m); hi++; end

      // short req1 pulse between ticks is never seen
      hi = 0;
      while (!(clk_send === 1'b0 && pa1 === 1'b0 && hi > 0 && dut.r_clk_send === 1'b0 && prev == 1) && hi < 4 * HD) begin
         prev = clk_send;
         @(negedge clk_12m); hi++;
      end
      repeat (20) @(negedge clk_12m);
      req1 = 1; data1 = 16'h1357;
      repeat (10) @(negedge clk_12m);
      req1 = 0;
      act = 0; lo = ack_cnt;
      repeat (4 * HD) begin
         @(negedge clk_12m);
         if (tx_en || tx_data || busy) act++;
      end
      chk("pulse_line_idle", act, 0);
      chk("pulse_no_ack", ack_cnt - lo, 0);

      // reset mid data bit 7, then a fresh frame
      data0 = 16'hC3A5; req0 = 1;
      wait_ack(id, at, ok);
      req0 = 0;
      for (int k = 0; k < 10; k++) wait_rise(ok);
      repeat (20) @(negedge clk_12m);
      chk("mid_frame_en", tx_en, 1);
      reset = 0;
      #1;
      chk("abort_tx_en", tx_en, 0);
      chk("abort_tx_data", tx_data, 0);
      chk("abort_clk_send", clk_send, 0);
      chk("abort_busy", busy, 0);
      repeat (5) @(negedge clk_12m);
      reset = 1; last_model = 1;
      data0 = 16'h3C5A; req0 = 1;
      wait_ack(id, at, ok);
      req0 = 0;
      chk("fresh_ack_id", id, 0);
      if (ok) check_frame(16'h3C5A, 1'b1, "fresh");
      last_model = 0;

      // randomized traffic against the arbitration/framing model
      begin
         bit p0 = 0, p1 = 0, eid;
         logic [1:0] r;
         logic [W-1:0] ew;
         for (int f = 0; f < 6; f++) begin
            r = 2'($urandom_range(0, 3));
            if (!p0 && (r[0] || (!p1 && !r[1]))) begin p0 = 1; data0 = W'($urandom); end
            if (!p1 && r[1]) begin p1 = 1; data1 = W'($urandom); end
            req0 = p0; req1 = p1;
            eid = (p0 && p1) ? !last_model : p1;
            ew = eid ? data1 : data0;
            wait_ack(id, at, ok);
            chk($sformatf("rand%0d_id", f), id, eid);
            chk($sformatf("rand%0d_grant_id", f), grant_id, eid);
            last_model = eid;
            if (eid) begin p1 = 0; data1 = W'($urandom); end
            else begin p0 = 0; data0 = W'($urandom); end
            req0 = p0; req1 = p1;
            if (ok) check_frame(ew, ($countones(ew) % 2) == 0, $sformatf("rand%0d", f));
         end
         req0 = 0; req1 = 0;
      end

      repeat (2) @(negedge clk_12m);
      chk("ack_pulse_shape", ack_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
